// File: rtl/gcbp_corr_rd_sched_if.sv
// -----------------------------------------------------------------------------
// gcbp_corr_rd_sched_if
//   Bundle of control, BRAM read-port and correlator-tag signals for the GCBP
//   correlator read scheduler.
//
//   Parameters
//     C_ADDR_W  BRAM address width
//     C_LINE_W  width of the line-index tag
//
//   Modports
//     slave   scheduler side: takes start/locations/ready, drives read port,
//             beat tags and status
//     master  controller/consumer side (mirror image of slave)
//
//   Optional: GCBP_CORR_SCHED_STATS_EN adds o_stall_cnt.
// -----------------------------------------------------------------------------
interface gcbp_corr_rd_sched_if #(
    parameter int unsigned C_ADDR_W = 9,
    parameter int unsigned C_LINE_W = 6
);
    logic                i_start;
    logic [1:0]          i_curr_frame_loc;
    logic [1:0]          i_prev_frame_loc;
    logic                i_corr_ready;
    logic                o_bram_rd_en;
    logic [C_ADDR_W-1:0] o_bram_rd_addr;
    logic                o_line_valid;
    logic [C_LINE_W-1:0] o_line_idx;
    logic                o_sel_prev;
    logic                o_busy;
    logic                o_done;
    logic                o_overrun;
`ifdef GCBP_CORR_SCHED_STATS_EN
    logic [15:0]         o_stall_cnt;
`endif

    modport slave (
        input  i_start, i_curr_frame_loc, i_prev_frame_loc, i_corr_ready,
        output o_bram_rd_en, o_bram_rd_addr, o_line_valid, o_line_idx, o_sel_prev,
               o_busy, o_done, o_overrun
`ifdef GCBP_CORR_SCHED_STATS_EN
        , output o_stall_cnt
`endif
    );

    modport master (
        output i_start, i_curr_frame_loc, i_prev_frame_loc, i_corr_ready,
        input  o_bram_rd_en, o_bram_rd_addr, o_line_valid, o_line_idx, o_sel_prev,
               o_busy, o_done, o_overrun
`ifdef GCBP_CORR_SCHED_STATS_EN
        , input o_stall_cnt
`endif
    );
endinterface

// File: rtl/gcbp_corr_rd_sched.sv
// -----------------------------------------------------------------------------
// gcbp_corr_rd_sched
//   Read-port scheduler for the GCBP sub-image BRAM array. A frame start walks
//   all lines of the current and previous sub-images, interleaving current and
//   previous reads line by line. Each returning data beat is tagged with its
//   line index and frame select; o_done pulses once the final beat has been
//   presented.
//
//   Ports
//     i_clk, i_resetn   clock, asynchronous active-low reset
//     bus (slave)       i_start, i_curr_frame_loc, i_prev_frame_loc,
//                       i_corr_ready in; o_bram_rd_en, o_bram_rd_addr,
//                       o_line_valid, o_line_idx, o_sel_prev, o_busy,
//                       o_done, o_overrun out
//
//   Optional feature macro: GCBP_CORR_SCHED_STATS_EN
//     Adds bus.o_stall_cnt: READ cycles with i_corr_ready low, cleared on an
//     accepted start, saturating at 16'hFFFF.
// -----------------------------------------------------------------------------
module gcbp_corr_rd_sched #(
    parameter int unsigned C_LINES           = 64,
    parameter int unsigned C_SUBIMAGE_OFFSET = 128,
    parameter int unsigned C_ADDR_W          = 9,
    parameter int unsigned C_RD_LATENCY      = 1
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    gcbp_corr_rd_sched_if.slave   bus
);

    localparam int unsigned BEATS  = 2 * C_LINES;
    localparam int unsigned K_W    = $clog2(BEATS);
    localparam int unsigned LINE_W = $clog2(C_LINES);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e              state_q;
    logic [K_W-1:0]      k_q;
    logic [1:0]          curr_q;
    logic [1:0]          prev_q;
    logic                rd_en_q;
    logic [C_ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]   iss_line_q;
    logic                iss_sel_q;
    logic                busy_q;
    logic                done_q;
    logic                overrun_q;

    logic [C_RD_LATENCY-1:0] vld_pipe_q;
    logic [C_RD_LATENCY-1:0] sel_pipe_q;
    logic [LINE_W-1:0]       line_pipe_q [C_RD_LATENCY];

`ifdef GCBP_CORR_SCHED_STATS_EN
    logic [15:0] stall_q;
`endif

    logic                start_ok;
    logic                issue;
    logic                last_issue;
    logic                last_valid;
    logic [1:0]          sel_loc;
    logic [LINE_W-1:0]   k_line;
    logic                k_sel;
    logic [C_ADDR_W-1:0] addr_d;

    always_comb begin
        start_ok = (state_q == StIdle) && bus.i_start;
        // The start cycle itself issues beat 0 so the first read lands the
        // cycle after i_start; until locations are latched use the inputs.
        issue    = bus.i_corr_ready && (start_ok || (state_q == StRead));
        k_line   = k_q[K_W-1:1];
        k_sel    = k_q[0];
        if (start_ok) begin
            sel_loc = k_sel ? bus.i_prev_frame_loc : bus.i_curr_frame_loc;
        end else begin
            sel_loc = k_sel ? prev_q : curr_q;
        end
        addr_d     = C_ADDR_W'(32'(sel_loc) * C_SUBIMAGE_OFFSET + 32'(k_line));
        last_issue = issue && (k_q == K_W'(BEATS - 1));
        last_valid = vld_pipe_q[C_RD_LATENCY-1] && sel_pipe_q[C_RD_LATENCY-1] &&
                     (line_pipe_q[C_RD_LATENCY-1] == LINE_W'(C_LINES - 1));
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= StIdle;
            k_q        <= '0;
            curr_q     <= '0;
            prev_q     <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            iss_line_q <= '0;
            iss_sel_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            vld_pipe_q <= '0;
            sel_pipe_q <= '0;
            for (int i = 0; i < int'(C_RD_LATENCY); i++) begin
                line_pipe_q[i] <= '0;
            end
`ifdef GCBP_CORR_SCHED_STATS_EN
            stall_q    <= '0;
`endif
        end else begin
            // Issue stage; address and tags hold while nothing issues.
            rd_en_q <= issue;
            if (issue) begin
                addr_q     <= addr_d;
                iss_line_q <= k_line;
                iss_sel_q  <= k_sel;
                k_q        <= last_issue ? '0 : k_q + 1'b1;
            end

            // Latency pipe is never stalled by ready.
            vld_pipe_q[0]  <= rd_en_q;
            sel_pipe_q[0]  <= iss_sel_q;
            line_pipe_q[0] <= iss_line_q;
            for (int i = int'(C_RD_LATENCY) - 1; i > 0; i--) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                sel_pipe_q[i]  <= sel_pipe_q[i-1];
                line_pipe_q[i] <= line_pipe_q[i-1];
            end

            if (bus.i_start && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end

            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        curr_q    <= bus.i_curr_frame_loc;
                        prev_q    <= bus.i_prev_frame_loc;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StRead;
`ifdef GCBP_CORR_SCHED_STATS_EN
                        stall_q   <= '0;
`endif
                    end
                end
                StRead: begin
`ifdef GCBP_CORR_SCHED_STATS_EN
                    if (!bus.i_corr_ready && (stall_q != 16'hFFFF)) begin
                        stall_q <= stall_q + 16'd1;
                    end
`endif
                    if (last_issue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_valid) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_bram_rd_en   = rd_en_q;
    assign bus.o_bram_rd_addr = addr_q;
    assign bus.o_line_valid   = vld_pipe_q[C_RD_LATENCY-1];
    assign bus.o_line_idx     = line_pipe_q[C_RD_LATENCY-1];
    assign bus.o_sel_prev     = sel_pipe_q[C_RD_LATENCY-1];
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_overrun      = overrun_q;
`ifdef GCBP_CORR_SCHED_STATS_EN
    assign bus.o_stall_cnt    = stall_q;
`endif

endmodule

// File: tb/tb_gcbp_corr_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_gcbp_corr_rd_sched
//   Directed bench for gcbp_corr_rd_sched. Three instances with read latency
//   1, 2 and 3 share one stimulus; a negedge monitor logs issues, valid beats
//   and done pulses with their cycle numbers, and each scenario task compares
//   the logs against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_gcbp_corr_rd_sched;

    localparam int AW  = 9;
    localparam int NB  = 128;
    localparam int LOG = 1024;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic       ready  = 1'b0;
    logic [1:0] curr   = 2'd0;
    logic [1:0] prev   = 2'd0;
    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcbp_corr_rd_sched_if #(.C_ADDR_W(AW), .C_LINE_W(6)) u_if0 ();
    gcbp_corr_rd_sched_if #(.C_ADDR_W(AW), .C_LINE_W(6)) u_if1 ();
    gcbp_corr_rd_sched_if #(.C_ADDR_W(AW), .C_LINE_W(6)) u_if2 ();

    gcbp_corr_rd_sched #(.C_LINES(64), .C_SUBIMAGE_OFFSET(128), .C_ADDR_W(AW),
                         .C_RD_LATENCY(1))
        u_dut0 (.i_clk(clk), .i_resetn(resetn), .bus(u_if0));
    gcbp_corr_rd_sched #(.C_LINES(64), .C_SUBIMAGE_OFFSET(128), .C_ADDR_W(AW),
                         .C_RD_LATENCY(2))
        u_dut1 (.i_clk(clk), .i_resetn(resetn), .bus(u_if1));
    gcbp_corr_rd_sched #(.C_LINES(64), .C_SUBIMAGE_OFFSET(128), .C_ADDR_W(AW),
                         .C_RD_LATENCY(3))
        u_dut2 (.i_clk(clk), .i_resetn(resetn), .bus(u_if2));

    assign u_if0.i_start = start;
    assign u_if0.i_curr_frame_loc = curr;
    assign u_if0.i_prev_frame_loc = prev;
    assign u_if0.i_corr_ready = ready;
    assign u_if1.i_start = start;
    assign u_if1.i_curr_frame_loc = curr;
    assign u_if1.i_prev_frame_loc = prev;
    assign u_if1.i_corr_ready = ready;
    assign u_if2.i_start = start;
    assign u_if2.i_curr_frame_loc = curr;
    assign u_if2.i_prev_frame_loc = prev;
    assign u_if2.i_corr_ready = ready;

    logic          rd_en [3];
    logic [AW-1:0] addr  [3];
    logic          vld   [3];
    logic [5:0]    line  [3];
    logic          sel   [3];
    logic          busy  [3];
    logic          done  [3];
    logic          ovr   [3];

    assign rd_en[0] = u_if0.o_bram_rd_en;
    assign addr[0]  = u_if0.o_bram_rd_addr;
    assign vld[0]   = u_if0.o_line_valid;
    assign line[0]  = u_if0.o_line_idx;
    assign sel[0]   = u_if0.o_sel_prev;
    assign busy[0]  = u_if0.o_busy;
    assign done[0]  = u_if0.o_done;
    assign ovr[0]   = u_if0.o_overrun;
    assign rd_en[1] = u_if1.o_bram_rd_en;
    assign addr[1]  = u_if1.o_bram_rd_addr;
    assign vld[1]   = u_if1.o_line_valid;
    assign line[1]  = u_if1.o_line_idx;
    assign sel[1]   = u_if1.o_sel_prev;
    assign busy[1]  = u_if1.o_busy;
    assign done[1]  = u_if1.o_done;
    assign ovr[1]   = u_if1.o_overrun;
    assign rd_en[2] = u_if2.o_bram_rd_en;
    assign addr[2]  = u_if2.o_bram_rd_addr;
    assign vld[2]   = u_if2.o_line_valid;
    assign line[2]  = u_if2.o_line_idx;
    assign sel[2]   = u_if2.o_sel_prev;
    assign busy[2]  = u_if2.o_busy;
    assign done[2]  = u_if2.o_done;
    assign ovr[2]   = u_if2.o_overrun;

`ifdef GCBP_CORR_SCHED_STATS_EN
    logic [15:0] stall [3];
    assign stall[0] = u_if0.o_stall_cnt;
    assign stall[1] = u_if1.o_stall_cnt;
    assign stall[2] = u_if2.o_stall_cnt;
`endif

    // Event logs, written only by the monitor.
    int            iss_n  [3] = '{0, 0, 0};
    int            vld_n  [3] = '{0, 0, 0};
    int            done_n [3] = '{0, 0, 0};
    int            done_cyc [3] = '{0, 0, 0};
    logic [AW-1:0] iss_addr [3][LOG];
    int            iss_cyc  [3][LOG];
    logic [5:0]    vld_line [3][LOG];
    logic          vld_sel  [3][LOG];
    int            vld_cyc  [3][LOG];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_en[d] === 1'b1) begin
                iss_addr[d][iss_n[d] % LOG] <= addr[d];
                iss_cyc[d][iss_n[d] % LOG]  <= cyc;
                iss_n[d] <= iss_n[d] + 1;
            end
            if (vld[d] === 1'b1) begin
                vld_line[d][vld_n[d] % LOG] <= line[d];
                vld_sel[d][vld_n[d] % LOG]  <= sel[d];
                vld_cyc[d][vld_n[d] % LOG]  <= cyc;
                vld_n[d] <= vld_n[d] + 1;
            end
            if (done[d] === 1'b1) begin
                done_cyc[d] <= cyc;
                done_n[d]   <= done_n[d] + 1;
            end
        end
    end

    // Reference model: issue cycle of beat k for a start in cycle t, with
    // every beat from gap_from onward pushed back by gap cycles.
    function automatic int exp_iss(input int t, input int k, input int gap_from,
                                   input int gap);
        return t + 1 + k + ((k >= gap_from) ? gap : 0);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int c, input int p, input int k);
        int loc;
        loc = (k % 2 == 1) ? p : c;
        return AW'((loc * 128 + k / 2) % 512);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] c, input logic [1:0] p, output int t);
        curr  = c;
        prev  = p;
        start = 1'b1;
        t     = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit to);
        to = 1'b1;
        for (int n = 0; n < bound; n++) begin
            step(1);
            if ((busy[0] | busy[1] | busy[2]) === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [20:0] v;
        resetn = 1'b0;
        ready  = 1'b0;
        step(3);
        for (int d = 0; d < 3; d++) begin
            v = {rd_en[d], addr[d], vld[d], line[d], sel[d], busy[d], done[d], ovr[d]};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h want 0", d, v);
            end
        end
        resetn = 1'b1;
        step(3);
        for (int d = 0; d < 3; d++) begin
            v = {rd_en[d], addr[d], vld[d], line[d], sel[d], busy[d], done[d], ovr[d]};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL idle_outputs dut%0d: got %h want 0", d, v);
            end
        end
    endtask

    // curr=1, prev=2, ready held high: 128 interleaved issues, tagged beats
    // L cycles later, done one cycle after the last beat.
    task automatic test_basic();
        int t; int bi[3]; int bv[3]; int bd[3]; bit to; int bad; int fk; int ix;
        ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            bi[d] = iss_n[d]; bv[d] = vld_n[d]; bd[d] = done_n[d];
        end
        pulse_start(2'd1, 2'd2, t);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy dut%0d: got %b want 1", d, busy[d]);
            end
        end
        wait_idle(400, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL basic_timeout: busy still high after 400 cycles, want idle");
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (iss_n[d] - bi[d] != NB || vld_n[d] - bv[d] != NB) begin
                errors++;
                $display("FAIL basic_counts dut%0d: got issues=%0d valids=%0d want %0d each",
                         d, iss_n[d] - bi[d], vld_n[d] - bv[d], NB);
            end
            bad = 0; fk = 0;
            for (int k = 0; k < NB; k++) begin
                ix = (bi[d] + k) % LOG;
                if (iss_addr[d][ix] !== exp_addr(1, 2, k) ||
                    iss_cyc[d][ix] != exp_iss(t, k, NB, 0)) begin
                    if (bad == 0) fk = k;
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                ix = (bi[d] + fk) % LOG;
                $display("FAIL basic_issue dut%0d: %0d bad, k=%0d got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                         d, bad, fk, iss_addr[d][ix], iss_cyc[d][ix] - t,
                         exp_addr(1, 2, fk), exp_iss(t, fk, NB, 0) - t);
            end
            bad = 0; fk = 0;
            for (int k = 0; k < NB; k++) begin
                ix = (bv[d] + k) % LOG;
                if (vld_line[d][ix] !== 6'(k / 2) || vld_sel[d][ix] !== 1'(k % 2) ||
                    vld_cyc[d][ix] != exp_iss(t, k, NB, 0) + d + 1) begin
                    if (bad == 0) fk = k;
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                ix = (bv[d] + fk) % LOG;
                $display("FAIL basic_valid dut%0d: %0d bad, k=%0d got line=%0d sel=%0d cyc=%0d want line=%0d sel=%0d cyc=%0d",
                         d, bad, fk, vld_line[d][ix], vld_sel[d][ix], vld_cyc[d][ix] - t,
                         fk / 2, fk % 2, exp_iss(t, fk, NB, 0) + d + 1 - t);
            end
            checks++;
            if (done_n[d] - bd[d] != 1 || done_cyc[d] != t + NB + d + 2) begin
                errors++;
                $display("FAIL basic_done dut%0d: got pulses=%0d at T+%0d want 1 at T+%0d",
                         d, done_n[d] - bd[d], done_cyc[d] - t, NB + d + 2);
            end
        end
    endtask

    // Ready dropped for 5 cycles just before beat 10 would issue.
    task automatic test_stall();
        int t; int bi[3]; int bd[3]; bit to; int bad; int fk; int ix;
        ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            bi[d] = iss_n[d]; bd[d] = done_n[d];
        end
        pulse_start(2'd0, 2'd2, t);
        step(9);
        ready = 1'b0;
        step(5);
        ready = 1'b1;
        wait_idle(400, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stall_timeout: busy still high after 400 cycles, want idle");
        end
        for (int d = 0; d < 3; d++) begin
            bad = 0; fk = 0;
            for (int k = 0; k < NB; k++) begin
                ix = (bi[d] + k) % LOG;
                if (iss_addr[d][ix] !== exp_addr(0, 2, k) ||
                    iss_cyc[d][ix] != exp_iss(t, k, 10, 5)) begin
                    if (bad == 0) fk = k;
                    bad++;
                end
            end
            checks++;
            if (bad != 0 || iss_n[d] - bi[d] != NB) begin
                errors++;
                ix = (bi[d] + fk) % LOG;
                $display("FAIL stall_issue dut%0d: %0d bad of %0d, k=%0d got addr=%0d cyc=T+%0d want addr=%0d cyc=T+%0d",
                         d, bad, iss_n[d] - bi[d], fk, iss_addr[d][ix], iss_cyc[d][ix] - t,
                         exp_addr(0, 2, fk), exp_iss(t, fk, 10, 5) - t);
            end
            checks++;
            if (done_n[d] - bd[d] != 1 || done_cyc[d] != t + NB + 5 + d + 2) begin
                errors++;
                $display("FAIL stall_done dut%0d: got pulses=%0d at T+%0d want 1 at T+%0d",
                         d, done_n[d] - bd[d], done_cyc[d] - t, NB + 5 + d + 2);
            end
`ifdef GCBP_CORR_SCHED_STATS_EN
            checks++;
            if (stall[d] !== 16'd5) begin
                errors++;
                $display("FAIL stall_cnt dut%0d: got %0d want 5", d, stall[d]);
            end
`endif
        end
    endtask

    // Locations change mid-pass and a second start lands at beat 60; the
    // pass keeps its latched locations, o_overrun sets, and the next idle
    // start clears it and uses new locations (including location 3).
    task automatic test_overrun();
        int t; int t2; int bi[3]; int bd[3]; bit to; int bad; int fk; int ix;
        ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            bi[d] = iss_n[d]; bd[d] = done_n[d];
        end
        pulse_start(2'd0, 2'd1, t);
        step(4);
        curr = 2'd3;
        prev = 2'd3;
        step(56);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle(400, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL overrun_timeout: busy still high after 400 cycles, want idle");
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ovr[d] !== 1'b1) begin
                errors++;
                $display("FAIL overrun_set dut%0d: got %b want 1", d, ovr[d]);
            end
            bad = 0; fk = 0;
            for (int k = 0; k < NB; k++) begin
                ix = (bi[d] + k) % LOG;
                if (iss_addr[d][ix] !== exp_addr(0, 1, k) ||
                    iss_cyc[d][ix] != exp_iss(t, k, NB, 0)) begin
                    if (bad == 0) fk = k;
                    bad++;
                end
            end
            checks++;
            if (bad != 0 || iss_n[d] - bi[d] != NB) begin
                errors++;
                ix = (bi[d] + fk) % LOG;
                $display("FAIL overrun_issue dut%0d: %0d bad of %0d, k=%0d got addr=%0d want addr=%0d",
                         d, bad, iss_n[d] - bi[d], fk, iss_addr[d][ix], exp_addr(0, 1, fk));
            end
            checks++;
            if (done_n[d] - bd[d] != 1 || done_cyc[d] != t + NB + d + 2) begin
                errors++;
                $display("FAIL overrun_done dut%0d: got pulses=%0d at T+%0d want 1 at T+%0d",
                         d, done_n[d] - bd[d], done_cyc[d] - t, NB + d + 2);
            end
            bi[d] = iss_n[d];
        end
        pulse_start(2'd3, 2'd2, t2);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ovr[d] !== 1'b0) begin
                errors++;
                $display("FAIL overrun_clear dut%0d: got %b want 0", d, ovr[d]);
            end
        end
        wait_idle(400, to);
        for (int d = 0; d < 3; d++) begin
            bad = 0; fk = 0;
            for (int k = 0; k < NB; k++) begin
                ix = (bi[d] + k) % LOG;
                if (iss_addr[d][ix] !== exp_addr(3, 2, k)) begin
                    if (bad == 0) fk = k;
                    bad++;
                end
            end
            checks++;
            if (bad != 0 || iss_n[d] - bi[d] != NB) begin
                errors++;
                ix = (bi[d] + fk) % LOG;
                $display("FAIL newloc_issue dut%0d: %0d bad of %0d, k=%0d got addr=%0d want addr=%0d",
                         d, bad, iss_n[d] - bi[d], fk, iss_addr[d][ix], exp_addr(3, 2, fk));
            end
        end
    endtask

    // L=3 instance, curr=2, prev=0: addresses 256,0,257,1,... and each beat
    // valid exactly 3 cycles after its issue.
    task automatic test_latency3();
        int t; int bi; int bv; int bd; bit to; int bad; int fk; int ix; int iv;
        ready = 1'b1;
        bi = iss_n[2]; bv = vld_n[2]; bd = done_n[2];
        pulse_start(2'd2, 2'd0, t);
        wait_idle(400, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL lat3_timeout: busy still high after 400 cycles, want idle");
        end
        bad = 0; fk = 0;
        for (int k = 0; k < NB; k++) begin
            ix = (bi + k) % LOG;
            iv = (bv + k) % LOG;
            if (iss_addr[2][ix] !== exp_addr(2, 0, k) ||
                vld_cyc[2][iv] != exp_iss(t, k, NB, 0) + 3 ||
                vld_line[2][iv] !== 6'(k / 2) || vld_sel[2][iv] !== 1'(k % 2)) begin
                if (bad == 0) fk = k;
                bad++;
            end
        end
        checks++;
        if (bad != 0 || vld_n[2] - bv != NB) begin
            errors++;
            ix = (bi + fk) % LOG;
            iv = (bv + fk) % LOG;
            $display("FAIL lat3_beats: %0d bad of %0d, k=%0d got addr=%0d valid=T+%0d want addr=%0d valid=T+%0d",
                     bad, vld_n[2] - bv, fk, iss_addr[2][ix], vld_cyc[2][iv] - t,
                     exp_addr(2, 0, fk), exp_iss(t, fk, NB, 0) + 3 - t);
        end
        checks++;
        if (done_n[2] - bd != 1 || done_cyc[2] != t + NB + 4) begin
            errors++;
            $display("FAIL lat3_done: got pulses=%0d at T+%0d want 1 at T+%0d",
                     done_n[2] - bd, done_cyc[2] - t, NB + 4);
        end
    endtask

    // Asynchronous reset at beat 40: outputs clear immediately, in-flight
    // beats vanish, no done; a following start runs a complete pass.
    task automatic test_reset_midpass();
        int t; int sv[3]; int sd[3]; int bi[3]; bit to; logic [20:0] v;
        ready = 1'b1;
        pulse_start(2'd1, 2'd0, t);
        step(40);
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            v = {rd_en[d], addr[d], vld[d], line[d], sel[d], busy[d], done[d], ovr[d]};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: got %h want 0", d, v);
            end
            sv[d] = vld_n[d];
            sd[d] = done_n[d];
        end
        step(2);
        resetn = 1'b1;
        step(20);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (vld_n[d] != sv[d] || done_n[d] != sd[d] || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet dut%0d: got valids=%0d dones=%0d busy=%b want 0 0 0",
                         d, vld_n[d] - sv[d], done_n[d] - sd[d], busy[d]);
            end
            bi[d] = iss_n[d];
        end
        pulse_start(2'd2, 2'd1, t);
        wait_idle(400, to);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (to || iss_n[d] - bi[d] != NB || done_n[d] - sd[d] != 1 ||
                done_cyc[d] != t + NB + d + 2) begin
                errors++;
                $display("FAIL midreset_rerun dut%0d: got issues=%0d dones=%0d done=T+%0d want %0d 1 T+%0d",
                         d, iss_n[d] - bi[d], done_n[d] - sd[d], done_cyc[d] - t, NB, NB + d + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_latency3();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
